// File: rtl/csr_reg_ext.sv
// rtl/csr_reg_ext.sv - single CSR cell with CSRRW/CSRRS/CSRRC decode, write masks,
// hardware update port, optional event counter and sticky software-write lock.
module csr_reg_ext #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] SW_WMASK  = '1,
  parameter logic [WIDTH-1:0] HW_WMASK  = '1,
  parameter bit               COUNTER   = 1'b0,
  parameter bit               LOCKABLE  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       csr_op_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             hw_we_i,
  input  logic [WIDTH-1:0] hw_wdata_i,
  input  logic             cnt_en_i,
  input  logic             lock_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             locked_o,
  output logic             ovf_o,
  output logic             sw_wr_o
);

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] sw_cand;
  logic             locked_q;
  logic             sw_acc;
  logic             cnt_inc;
  logic             ovf_next;
  logic             locked_next;

  assign sw_acc = (csr_op_i != OP_NONE) && !locked_q;

  always_comb begin
    sw_cand = q;
    case (csr_op_i)
      OP_WRITE: sw_cand = wdata_i;
      OP_SET:   sw_cand = q | wdata_i;
      OP_CLEAR: sw_cand = q & ~wdata_i;
      default:  sw_cand = q;
    endcase
  end

  // Strict priority: software > hardware > counter; losers are discarded, not merged.
  assign cnt_inc = COUNTER && !sw_acc && !hw_we_i && cnt_en_i;

  always_comb begin
    q_next = q;
    if (sw_acc) begin
      q_next = (sw_cand & SW_WMASK) | (q & ~SW_WMASK);
    end else if (hw_we_i) begin
      q_next = (hw_wdata_i & HW_WMASK) | (q & ~HW_WMASK);
    end else if (cnt_inc) begin
      q_next = q + 1'b1;
    end
  end

  // Only a genuine wrap by increment flags overflow; a write to all ones does not.
  assign ovf_next    = cnt_inc && (q == {WIDTH{1'b1}});
  assign locked_next = locked_q | (LOCKABLE && lock_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q        <= RESET_VAL;
      locked_q <= 1'b0;
      ovf_o    <= 1'b0;
      sw_wr_o  <= 1'b0;
    end else begin
      q        <= q_next;
      locked_q <= locked_next;
      ovf_o    <= ovf_next;
      sw_wr_o  <= sw_acc;
    end
  end

  assign rdata_o  = q;
  assign locked_o = locked_q;

endmodule

// File: tb/tb_csr_reg_ext.sv
// tb/tb_csr_reg_ext.sv - directed bench for csr_reg_ext: masked ops, priority,
// counter wrap, lock, and the configurations where counter/lock are disabled.
module tb_csr_reg_ext;

  logic       clk;
  logic       rst_n;
  logic [1:0] op0, op1;
  logic [7:0] wd0, wd1, hwd0, hwd1;
  logic       hwe0, hwe1, cnt0, cnt1, lk0, lk1;
  logic [7:0] rd0, rd1;
  logic       locked0, locked1, ovf0, ovf1, sw0, sw1;

  int ntests = 0;
  int nfail  = 0;

  typedef struct {
    string      tag;
    int         d;
    logic [7:0] q;
    logic       l;
    logic       o;
    logic       s;
  } exp_t;

  exp_t sb[$];

  csr_reg_ext #(
    .WIDTH(8), .RESET_VAL(8'h5A), .SW_WMASK(8'h0F), .HW_WMASK(8'hFF),
    .COUNTER(1'b0), .LOCKABLE(1'b0)
  ) u_d0 (
    .clk(clk), .rst_n(rst_n), .csr_op_i(op0), .wdata_i(wd0),
    .hw_we_i(hwe0), .hw_wdata_i(hwd0), .cnt_en_i(cnt0), .lock_i(lk0),
    .rdata_o(rd0), .locked_o(locked0), .ovf_o(ovf0), .sw_wr_o(sw0)
  );

  csr_reg_ext #(
    .WIDTH(8), .RESET_VAL(8'h5A), .SW_WMASK(8'hFF), .HW_WMASK(8'hFF),
    .COUNTER(1'b1), .LOCKABLE(1'b1)
  ) u_d1 (
    .clk(clk), .rst_n(rst_n), .csr_op_i(op1), .wdata_i(wd1),
    .hw_we_i(hwe1), .hw_wdata_i(hwd1), .cnt_en_i(cnt1), .lock_i(lk1),
    .rdata_o(rd1), .locked_o(locked1), .ovf_o(ovf1), .sw_wr_o(sw1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input int d, input logic [7:0] q,
                      input logic l, input logic o, input logic s);
    exp_t e;
    e.tag = tag; e.d = d; e.q = q; e.l = l; e.o = o; e.s = s;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    logic [7:0] aq;
    logic al, ao, as;
    if (sb.size() == 0) begin
      ntests++;
      nfail++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    aq = (e.d == 0) ? rd0 : rd1;
    al = (e.d == 0) ? locked0 : locked1;
    ao = (e.d == 0) ? ovf0 : ovf1;
    as = (e.d == 0) ? sw0 : sw1;
    ntests++;
    assert (aq === e.q) else begin
      nfail++;
      $error("FAIL %s.rdata observed=%h expected=%h", e.tag, aq, e.q);
    end
    ntests++;
    assert (al === e.l) else begin
      nfail++;
      $error("FAIL %s.locked observed=%b expected=%b", e.tag, al, e.l);
    end
    ntests++;
    assert (ao === e.o) else begin
      nfail++;
      $error("FAIL %s.ovf observed=%b expected=%b", e.tag, ao, e.o);
    end
    ntests++;
    assert (as === e.s) else begin
      nfail++;
      $error("FAIL %s.sw_wr observed=%b expected=%b", e.tag, as, e.s);
    end
  endtask

  task automatic idle_all();
    op0 = 2'b00; wd0 = 8'h00; hwe0 = 1'b0; hwd0 = 8'h00; cnt0 = 1'b0; lk0 = 1'b0;
    op1 = 2'b00; wd1 = 8'h00; hwe1 = 1'b0; hwd1 = 8'h00; cnt1 = 1'b0; lk1 = 1'b0;
  endtask

  // Drive one cycle of stimulus on DUT d, queue the outcome expected after the edge.
  task automatic step(input string tag, input int d, input logic [1:0] op,
                      input logic [7:0] wd, input logic hwe, input logic [7:0] hwd,
                      input logic cnt, input logic lk, input logic [7:0] eq,
                      input logic el, input logic eo, input logic es);
    idle_all();
    if (d == 0) begin
      op0 = op; wd0 = wd; hwe0 = hwe; hwd0 = hwd; cnt0 = cnt; lk0 = lk;
    end else begin
      op1 = op; wd1 = wd; hwe1 = hwe; hwd1 = hwd; cnt1 = cnt; lk1 = lk;
    end
    push(tag, d, eq, el, eo, es);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_all();
    repeat (2) @(posedge clk);
    #1;
    push("rst_d0", 0, 8'h5A, 1'b0, 1'b0, 1'b0); pop_check();
    push("rst_d1", 1, 8'h5A, 1'b0, 1'b0, 1'b0); pop_check();
    rst_n = 1'b1;
    step("rel_d0", 0, 2'b00, 8'h00, 0, 8'h00, 0, 0, 8'h5A, 0, 0, 0);

    // Software ops through SW_WMASK=0F
    step("wr_ff",  0, 2'b01, 8'hFF, 0, 8'h00, 0, 0, 8'h5F, 0, 0, 1);
    step("set_03", 0, 2'b10, 8'h03, 0, 8'h00, 0, 0, 8'h5F, 0, 0, 1);
    step("clr_0c", 0, 2'b11, 8'h0C, 0, 8'h00, 0, 0, 8'h53, 0, 0, 1);
    step("idle0",  0, 2'b00, 8'h00, 0, 8'h00, 0, 0, 8'h53, 0, 0, 0);
    step("set_0",  0, 2'b10, 8'h00, 0, 8'h00, 0, 0, 8'h53, 0, 0, 1);

    // Software beats hardware in the same cycle
    step("prio_sw", 1, 2'b01, 8'h11, 1, 8'h22, 0, 0, 8'h11, 0, 0, 1);
    step("prio_hw", 1, 2'b00, 8'h00, 1, 8'h22, 0, 0, 8'h22, 0, 0, 0);

    // Counter wrap
    step("hw_fd",  1, 2'b00, 8'h00, 1, 8'hFD, 0, 0, 8'hFD, 0, 0, 0);
    step("cnt_fe", 1, 2'b00, 8'h00, 0, 8'h00, 1, 0, 8'hFE, 0, 0, 0);
    step("cnt_ff", 1, 2'b00, 8'h00, 0, 8'h00, 1, 0, 8'hFF, 0, 0, 0);
    step("cnt_00", 1, 2'b00, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0, 1, 0);
    step("cnt_01", 1, 2'b00, 8'h00, 0, 8'h00, 1, 0, 8'h01, 0, 0, 0);
    step("hw_ff",  1, 2'b00, 8'h00, 1, 8'hFF, 1, 0, 8'hFF, 0, 0, 0);
    step("sw_ff",  1, 2'b01, 8'hFF, 0, 8'h00, 1, 0, 8'hFF, 0, 0, 1);
    step("wrap2",  1, 2'b00, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0, 1, 0);
    step("cnt_02", 1, 2'b00, 8'h00, 0, 8'h00, 1, 0, 8'h01, 0, 0, 0);

    // Asynchronous reset mid-count, checked before any further edge
    cnt1 = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    push("arst_d1", 1, 8'h5A, 1'b0, 1'b0, 1'b0); pop_check();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Lock
    step("lock_wr", 1, 2'b01, 8'h33, 0, 8'h00, 0, 1, 8'h33, 1, 0, 1);
    step("lkd_wr",  1, 2'b01, 8'h44, 0, 8'h00, 0, 0, 8'h33, 1, 0, 0);
    step("lkd_clr", 1, 2'b11, 8'hFF, 0, 8'h00, 0, 0, 8'h33, 1, 0, 0);
    step("lkd_hw",  1, 2'b00, 8'h00, 1, 8'h44, 0, 0, 8'h44, 1, 0, 0);
    #1;
    rst_n = 1'b0;
    #1;
    push("unlock", 1, 8'h5A, 1'b0, 1'b0, 1'b0); pop_check();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Lock and counter inputs ignored when those features are off
    step("nolock0", 0, 2'b00, 8'h00, 0, 8'h00, 1, 1, 8'h5A, 0, 0, 0);
    step("nolock1", 0, 2'b01, 8'h06, 0, 8'h00, 1, 1, 8'h56, 0, 0, 1);
    step("nolock2", 0, 2'b01, 8'h09, 0, 8'h00, 1, 0, 8'h59, 0, 0, 1);
    step("nocnt",   0, 2'b00, 8'h00, 0, 8'h00, 1, 0, 8'h59, 0, 0, 0);

    if (sb.size() != 0) begin
      ntests++;
      nfail++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
